sprite_pixel_fifo: RTL and testbench

//  Object pixel FIFO sitting directly downstream of the sprite fetch/evaluation stage in the PPU.
//  - Accepts one fetched sprite row at a time: two tile bytes, the OAM attribute byte and the slot index.
//  - Merges that row into an 8-slot pixel shift register with DMG/CGB priority rules.
//  - Presents the head pixel to the BG/OBJ mixer each pixel clock.

---
 rtl/sprite_pixel_fifo_pkg.sv | 26 ++
 rtl/sprite_pixel_fifo_obj_row_decode.sv | 44 ++++
 rtl/sprite_pixel_fifo.sv | 152 +++++++++++++++
 tb/tb_sprite_pixel_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pixel_fifo_pkg.sv
// Shared definitions for the sprite object pixel FIFO.
// Holds the OAM attribute bit positions, the slot field widths, the per-slot
// pixel record and the empty-slot constant.
package sprite_pixel_fifo_pkg;

   localparam int DEPTH      = 8;   // one sprite row is 8 pixels wide
   localparam int IDX_W_DEF  = 4;   // 10 sprite slots per line
   localparam int COLOR_W    = 2;
   localparam int CGB_PAL_W  = 3;

   // OAM attribute byte bit positions
   localparam int ATTR_PRIO  = 7;
   localparam int ATTR_XFLIP = 5;
   localparam int ATTR_PAL   = 4;

   // Per-slot pixel record (the sprite index is kept alongside, sized by IDX_W)
   typedef struct packed {
      logic [COLOR_W-1:0]   color;
      logic                 pal;
      logic [CGB_PAL_W-1:0] cgb_pal;
      logic                 prio;
   } pix_t;

   localparam pix_t PIX_EMPTY = '{color: 2'd0, pal: 1'b0, cgb_pal: 3'd0, prio: 1'b0};

endpackage

// File: rtl/sprite_pixel_fifo_obj_row_decode.sv
// obj_row_decode: combinational sprite row decoder.
// Turns the two bit-planes of one sprite row into eight 2-bit colours that
// are already aligned to the FIFO slots, honouring horizontal flip and the
// number of leading pixels skipped at the left screen edge.
// Ports:
//   tile0 / tile1 : low / high bit-plane, bit 7 is the leftmost pixel
//   xflip         : mirror the row horizontally
//   skip          : incoming pixel k+skip lands in slot k
//   color         : colour for each slot (0 where no incoming pixel lands)
module obj_row_decode
   import sprite_pixel_fifo_pkg::*;
(
   input  logic [7:0]                    tile0,
   input  logic [7:0]                    tile1,
   input  logic                          xflip,
   input  logic [2:0]                    skip,
   output logic [DEPTH-1:0][COLOR_W-1:0] color
);

   // Per-slot source pixel selection and bit-plane extraction
   always_comb begin : decode
      logic [3:0] src_s;
      logic [2:0] pos_s;
      color = '0;
      src_s = 4'd0;
      pos_s = 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
         src_s = 4'(k) + {1'b0, skip};
         // Pixel index 0 is bit 7 normally, bit 0 when flipped
         if (xflip) begin
            pos_s = src_s[2:0];
         end else begin
            pos_s = 3'd7 - src_s[2:0];
         end
         // Slots past the end of the skipped row receive nothing
         if (src_s < 4'd8) begin
            color[k] = {tile1[pos_s], tile0[pos_s]};
         end else begin
            color[k] = 2'd0;
         end
      end
   end

endmodule

// File: rtl/sprite_pixel_fifo.sv
// sprite_pixel_fifo: object pixel FIFO between sprite fetch and the BG/OBJ mixer.
// Merges one fetched sprite row at a time into an 8-slot pixel shift register
// (an already opaque slot always keeps its pixel) and presents slot 0 as the
// head pixel.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   ce             : pixel clock enable, state only advances when high
//   lcd_on         : low clears and holds the FIFO empty
//   isGBC          : selects CGB palette attributes
//   line_start     : clears all slots
//   load           : sprite row (tile0, tile1, attr, index, skip) valid
//   shift          : mixer consumed the head pixel
//   pix_*          : decode of the head slot
//   fifo_busy      : any slot still holds an opaque pixel
module sprite_pixel_fifo
   import sprite_pixel_fifo_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce,
   input  logic                 lcd_on,
   input  logic                 isGBC,
   input  logic                 line_start,
   input  logic                 load,
   input  logic [7:0]           tile0,
   input  logic [7:0]           tile1,
   input  logic [7:0]           attr,
   input  logic [IDX_W-1:0]     index,
   input  logic [2:0]           skip,
   input  logic                 shift,
   output logic                 pix_opaque,
   output logic [COLOR_W-1:0]   pix_color,
   output logic                 pix_pal,
   output logic [CGB_PAL_W-1:0] pix_cgb_pal,
   output logic                 pix_prio,
   output logic [IDX_W-1:0]     pix_index,
   output logic                 fifo_busy
);

   pix_t                          slots_r   [DEPTH];
   logic [IDX_W-1:0]              idx_r     [DEPTH];
   pix_t                          base_s    [DEPTH];
   logic [IDX_W-1:0]              base_idx_s[DEPTH];
   pix_t                          next_s    [DEPTH];
   logic [IDX_W-1:0]              next_idx_s[DEPTH];
   logic [DEPTH-1:0][COLOR_W-1:0] row_color_s;
   pix_t                          incoming_s;
   logic                          clear_s;
   logic                          unused_attr_s;

   // Attribute bits 6 and 3 carry VRAM bank / unused flags not needed here
   assign unused_attr_s = ^{attr[6], attr[3]};

   obj_row_decode u_decode (
      .tile0 (tile0),
      .tile1 (tile1),
      .xflip (attr[ATTR_XFLIP]),
      .skip  (skip),
      .color (row_color_s)
   );

   assign clear_s = ~lcd_on | line_start;

   // Shift (if requested), then merge the incoming row, then apply clear
   always_comb begin
      incoming_s.color   = 2'd0;
      incoming_s.pal     = attr[ATTR_PAL];
      // CGB palette is don't-care in DMG mode; keep it at zero there
      if (isGBC) begin
         incoming_s.cgb_pal = attr[2:0];
      end else begin
         incoming_s.cgb_pal = 3'd0;
      end
      incoming_s.prio    = attr[ATTR_PRIO];

      for (int i = 0; i < DEPTH; i++) begin
         base_s[i]     = slots_r[i];
         base_idx_s[i] = idx_r[i];
         next_s[i]     = slots_r[i];
         next_idx_s[i] = idx_r[i];
      end

      if (shift) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            base_s[i]     = slots_r[i+1];
            base_idx_s[i] = idx_r[i+1];
         end
         base_s[DEPTH-1]     = PIX_EMPTY;
         base_idx_s[DEPTH-1] = '0;
      end else begin
         base_s[DEPTH-1]     = slots_r[DEPTH-1];
         base_idx_s[DEPTH-1] = idx_r[DEPTH-1];
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (clear_s) begin
            next_s[i]     = PIX_EMPTY;
            next_idx_s[i] = '0;
         end else if (load && (base_s[i].color == 2'd0) && (row_color_s[i] != 2'd0)) begin
            // Earlier-fetched sprites own any slot they already made opaque
            next_s[i]       = incoming_s;
            next_s[i].color = row_color_s[i];
            next_idx_s[i]   = index;
         end else begin
            next_s[i]     = base_s[i];
            next_idx_s[i] = base_idx_s[i];
         end
      end
   end

   // Slot registers, advancing on pixel clock enable
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_r[i] <= PIX_EMPTY;
            idx_r[i]   <= '0;
         end
      end else if (ce) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_r[i] <= next_s[i];
            idx_r[i]   <= next_idx_s[i];
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_r[i] <= slots_r[i];
            idx_r[i]   <= idx_r[i];
         end
      end
   end

   assign pix_color   = slots_r[0].color;
   assign pix_opaque  = (slots_r[0].color != 2'd0);
   assign pix_pal     = slots_r[0].pal;
   assign pix_cgb_pal = slots_r[0].cgb_pal;
   assign pix_prio    = slots_r[0].prio;
   assign pix_index   = idx_r[0];

   // Busy while any slot still holds an opaque pixel
   always_comb begin
      fifo_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slots_r[i].color != 2'd0) begin
            fifo_busy = 1'b1;
         end else begin
            fifo_busy = fifo_busy;
         end
      end
   end

endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Directed self-checking bench for sprite_pixel_fifo.
module tb_sprite_pixel_fifo;
   import sprite_pixel_fifo_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       ce;
   logic       lcd_on;
   logic       isGBC;
   logic       line_start;
   logic       load;
   logic [7:0] tile0;
   logic [7:0] tile1;
   logic [7:0] attr;
   logic [3:0] index;
   logic [2:0] skip;
   logic       shift;
   logic       pix_opaque;
   logic [1:0] pix_color;
   logic       pix_pal;
   logic [2:0] pix_cgb_pal;
   logic       pix_prio;
   logic [3:0] pix_index;
   logic       fifo_busy;

   int tests  = 0;
   int failed = 0;

   sprite_pixel_fifo #(.IDX_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ce          (ce),
      .lcd_on      (lcd_on),
      .isGBC       (isGBC),
      .line_start  (line_start),
      .load        (load),
      .tile0       (tile0),
      .tile1       (tile1),
      .attr        (attr),
      .index       (index),
      .skip        (skip),
      .shift       (shift),
      .pix_opaque  (pix_opaque),
      .pix_color   (pix_color),
      .pix_pal     (pix_pal),
      .pix_cgb_pal (pix_cgb_pal),
      .pix_prio    (pix_prio),
      .pix_index   (pix_index),
      .fifo_busy   (fifo_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 2 units after the edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_row(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] a,
                          input logic [3:0] idx, input logic [2:0] sk);
      tile0 = t0;
      tile1 = t1;
      attr  = a;
      index = idx;
      skip  = sk;
   endtask

   task automatic clear_line();
      line_start = 1'b1;
      load       = 1'b0;
      shift      = 1'b0;
      tick();
      line_start = 1'b0;
   endtask

   initial begin
      logic [1:0] exp_col [9];
      reset_n = 1'b0; ce = 1'b1; lcd_on = 1'b1; isGBC = 1'b0; line_start = 1'b0;
      load = 1'b0; shift = 1'b0;
      set_row(8'h00, 8'h00, 8'h00, 4'd0, 3'd0);
      #3;
      chk("rst_opaque", {7'd0, pix_opaque}, 8'd0);
      chk("rst_busy",   {7'd0, fifo_busy},  8'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Plain row: colours 3,3,3,3,2,2,2,2 then transparent
      set_row(8'hF0, 8'hFF, 8'h00, 4'd0, 3'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("row_head", {6'd0, pix_color}, 8'd3);
      chk("row_busy", {7'd0, fifo_busy}, 8'd1);
      exp_col = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      shift = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("row_shift%0d", i), {6'd0, pix_color}, {6'd0, exp_col[i]});
      end
      shift = 1'b0;
      chk("row_empty_busy", {7'd0, fifo_busy}, 8'd0);
      chk("row_empty_opq",  {7'd0, pix_opaque}, 8'd0);

      // X-flipped row: 2,2,2,2,3,3,3,3
      set_row(8'hF0, 8'hFF, 8'h20, 4'd0, 3'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      exp_col = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
      chk("flip0", {6'd0, pix_color}, 8'd2);
      shift = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("flip%0d", i), {6'd0, pix_color}, {6'd0, exp_col[i]});
      end
      shift = 1'b0;
      clear_line();

      // Priority and DMG palette attributes
      set_row(8'hFF, 8'h00, 8'h90, 4'd5, 3'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("attr_color", {6'd0, pix_color}, 8'd1);
      chk("attr_prio",  {7'd0, pix_prio},  8'd1);
      chk("attr_pal",   {7'd0, pix_pal},   8'd1);
      chk("attr_index", {4'd0, pix_index}, 8'd5);
      clear_line();

      // CGB palette
      isGBC = 1'b1;
      set_row(8'hFF, 8'h00, 8'h05, 4'd2, 3'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("cgb_pal", {5'd0, pix_cgb_pal}, 8'd5);
      chk("cgb_dmgpal", {7'd0, pix_pal}, 8'd0);
      isGBC = 1'b0;
      clear_line();

      // Two overlapping rows: existing opaque pixels win, gaps filled by B
      set_row(8'hAA, 8'h00, 8'h00, 4'd1, 3'd0);
      load = 1'b1;
      tick();
      set_row(8'hFF, 8'h00, 8'h00, 4'd2, 3'd0);
      tick();
      load = 1'b0;
      chk("merge_idx0", {4'd0, pix_index}, 8'd1);
      chk("merge_col0", {6'd0, pix_color}, 8'd1);
      shift = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("merge_idx%0d", i), {4'd0, pix_index}, (i % 2 == 1) ? 8'd2 : 8'd1);
         chk($sformatf("merge_col%0d", i), {6'd0, pix_color}, 8'd1);
      end
      shift = 1'b0;
      clear_line();

      // Skip 3: five opaque pixels, then load+shift aligns new row to new head
      set_row(8'hFF, 8'hFF, 8'h00, 4'd3, 3'd3);
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("skip_head", {6'd0, pix_color}, 8'd3);
      set_row(8'hFF, 8'h00, 8'h00, 4'd7, 3'd0);
      load  = 1'b1;
      shift = 1'b1;
      #1;
      chk("ldsh_old_head", {4'd0, pix_index}, 8'd3);
      tick();
      load = 1'b0;
      // Head is old slot 1; old slots 1..4 opaque, new row fills the rest
      chk("ldsh_new_head", {4'd0, pix_index}, 8'd3);
      for (int i = 1; i <= 3; i++) tick();
      chk("ldsh_last_old", {6'd0, pix_color}, 8'd3);
      tick();
      chk("ldsh_new_col", {6'd0, pix_color}, 8'd1);
      chk("ldsh_new_idx", {4'd0, pix_index}, 8'd7);
      for (int i = 1; i <= 4; i++) tick();
      shift = 1'b0;
      chk("ldsh_drain", {7'd0, fifo_busy}, 8'd0);

      // Load with ce low is ignored
      ce = 1'b0;
      set_row(8'hFF, 8'hFF, 8'h00, 4'd4, 3'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      ce = 1'b1;
      tick();
      chk("ce_low_load", {7'd0, fifo_busy}, 8'd0);

      // line_start beats simultaneous load and shift
      load = 1'b1;
      tick();
      chk("fill_busy", {7'd0, fifo_busy}, 8'd1);
      line_start = 1'b1;
      shift = 1'b1;
      tick();
      line_start = 1'b0;
      load = 1'b0;
      shift = 1'b0;
      chk("ls_busy",  {7'd0, fifo_busy}, 8'd0);
      chk("ls_color", {6'd0, pix_color}, 8'd0);

      // lcd_on low clears and blocks loads
      load = 1'b1;
      tick();
      lcd_on = 1'b0;
      tick();
      load = 1'b0;
      chk("lcd_off_busy", {7'd0, fifo_busy}, 8'd0);
      lcd_on = 1'b1;

      // Asynchronous reset mid-line, visible before the next edge
      set_row(8'hFF, 8'hFF, 8'h90, 4'd9, 3'd0);
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("pre_rst_busy", {7'd0, fifo_busy}, 8'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_color", {6'd0, pix_color}, 8'd0);
      chk("arst_prio",  {7'd0, pix_prio},  8'd0);
      chk("arst_pal",   {7'd0, pix_pal},   8'd0);
      chk("arst_index", {4'd0, pix_index}, 8'd0);
      chk("arst_busy",  {7'd0, fifo_busy}, 8'd0);
      tick();
      reset_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
